// File: rtl/led_band_pkg.sv
// Shared definitions for the LED band grayscale sequencer.
//   state_t       : sequencer FSM states (PRE_LATCH/POST_LATCH only reached
//                   in builds with LATCH_BLANK_EN defined)
//   gs_bits()     : number of bits shifted per channel (data bits + LSB pad)
//   BIT_SEL_WIDTH : width of the bit select driven to the GS bit-mux
package led_band_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    SHIFT      = 3'd2,
    PRE_LATCH  = 3'd3,
    LATCH      = 3'd4,
    POST_LATCH = 3'd5
  } state_t;

  localparam int unsigned BIT_SEL_WIDTH = 4;

  function automatic int unsigned gs_bits(input int unsigned bit_per_color);
    return bit_per_color + 1;
  endfunction

endpackage

// File: rtl/led_band_gs_sequencer.sv
// Grayscale frame-load sequencer for a daisy-chained LED-driver band.
// Walks channels NB_CHANNELS-1 down to 0, addresses each channel word in
// frame RAM (1-cycle read latency), steps bit_sel MSB-first down to the pad
// bit for the downstream GS bit-mux, and generates SCLK and XLAT.
//
// Optional feature macro: LATCH_BLANK_EN adds the BLANK output together with
// one pre-latch and one post-latch cycle framing XLAT.
//
// Ports:
//   clk        system clock
//   nrst       asynchronous active-low reset
//   start      frame-load request, only honoured while idle
//   slice_idx  slice to load, captured with start
//   busy       high from the cycle after start is accepted through the latch
//   done       one-cycle pulse in the first idle cycle after a frame
//   r_addr     frame RAM address {slice, channel}, registered
//   bit_sel    bit select to the GS bit-mux (0 selects the pad bit)
//   SCLK       band shift clock, registered
//   XLAT       band latch pulse, registered
//   BLANK      band blank, high around XLAT (LATCH_BLANK_EN only)
module led_band_gs_sequencer
  import led_band_pkg::*;
#(
  parameter int unsigned BIT_PER_COLOR = 8,
  parameter int unsigned NB_CHANNELS   = 48,
  parameter int unsigned CH_WIDTH      = 6,
  parameter int unsigned SLICE_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start,
  input  logic [SLICE_WIDTH-1:0]          slice_idx,
  output logic                            busy,
  output logic                            done,
  output logic [SLICE_WIDTH+CH_WIDTH-1:0] r_addr,
  output logic [BIT_SEL_WIDTH-1:0]        bit_sel,
  output logic                            SCLK,
  output logic                            XLAT
`ifdef LATCH_BLANK_EN
  ,
  output logic                            BLANK
`endif
);

  if (gs_bits(BIT_PER_COLOR) > 16) begin : g_bpc_check
    $error("BIT_PER_COLOR must not exceed 15");
  end
  if (NB_CHANNELS > (2 ** CH_WIDTH)) begin : g_ch_check
    $error("NB_CHANNELS does not fit in CH_WIDTH");
  end

  localparam logic [BIT_SEL_WIDTH-1:0] TOP_BIT = BIT_SEL_WIDTH'(BIT_PER_COLOR);
  localparam logic [CH_WIDTH-1:0]      LAST_CH = CH_WIDTH'(NB_CHANNELS - 1);

  state_t              state;
  state_t              state_n;
  logic [CH_WIDTH-1:0] ch;
  logic                bit_end;

  assign ch      = r_addr[CH_WIDTH-1:0];
  // Last cycle of a channel: SCLK=1 phase of the pad bit.
  assign bit_end = (state == SHIFT) && SCLK && (bit_sel == '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = FETCH;
      FETCH: state_n = SHIFT;
      SHIFT: begin
        if (bit_end) begin
          if (ch != '0) begin
            state_n = FETCH;
          end else begin
`ifdef LATCH_BLANK_EN
            state_n = PRE_LATCH;
`else
            state_n = LATCH;
`endif
          end
        end
      end
`ifdef LATCH_BLANK_EN
      PRE_LATCH:  state_n = LATCH;
      LATCH:      state_n = POST_LATCH;
      POST_LATCH: state_n = IDLE;
`else
      LATCH:      state_n = IDLE;
`endif
      default:    state_n = IDLE;
    endcase
  end

  // Status/strobe outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_addr  <= '0;
      bit_sel <= '0;
      SCLK    <= 1'b0;
      XLAT    <= 1'b0;
`ifdef LATCH_BLANK_EN
      BLANK   <= 1'b1;
`endif
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state != IDLE) && (state_n == IDLE);
      XLAT  <= (state_n == LATCH);
`ifdef LATCH_BLANK_EN
      BLANK <= (state_n == PRE_LATCH) || (state_n == LATCH) ||
               (state_n == POST_LATCH);
`endif

      // SCLK toggles through SHIFT; it is 0 entering SHIFT and returns to 0
      // after the pad bit's high phase.
      SCLK <= (state == SHIFT) ? ~SCLK : 1'b0;

      if (state == FETCH) begin
        bit_sel <= TOP_BIT;
      end else if ((state == SHIFT) && SCLK && (bit_sel != '0)) begin
        bit_sel <= bit_sel - 1'b1;
      end

      if ((state == IDLE) && start) begin
        r_addr <= {slice_idx, LAST_CH};
      end else if (bit_end && (ch != '0)) begin
        r_addr[CH_WIDTH-1:0] <= ch - CH_WIDTH'(1);
      end
    end
  end

endmodule
